// File: rtl/sfx_arbiter.sv
// Menu sound-effect scheduler: latches four effect requests, plays them one at a
// time by fixed priority with a silence gap, and drives the shared tone generator.
module sfx_arbiter #(
    parameter int TICK_DIV = 50000,
    parameter int GAP_MS   = 10,
    parameter int DUR0_MS  = 80,
    parameter int DUR1_MS  = 80,
    parameter int DUR2_MS  = 40,
    parameter int DUR3_MS  = 500,
    parameter int HP0      = 56818,
    parameter int HP1      = 28409,
    parameter int HP2      = 14205,
    parameter int HP3      = 113636
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  req,
    input  logic        gameplay_active,
    output logic        tone_en,
    output logic [16:0] tone_half_period,
    output logic [1:0]  tone_sel,
    output logic [3:0]  grant,
    output logic [3:0]  pending,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE,
        PLAY,
        GAP
    } state_t;

    localparam logic [15:0] PRESC_LAST = 16'(TICK_DIV - 1);
    localparam logic [8:0]  GAP_LAST   = 9'(GAP_MS - 1);

    state_t      state;
    logic [3:0]  req_q;
    logic [15:0] prescaler;
    logic [8:0]  ms_cnt;

    logic [3:0]  edges;
    logic [3:0]  accepted;
    logic [3:0]  pend_upd;
    logic [3:0]  pend_next;
    logic        tick_wrap;
    logic        play_done;
    logic        gap_done;
    logic        preempt;
    logic        retrig;
    logic        to_gap;
    logic        to_idle;
    logic        start_play;
    logic [1:0]  start_idx;
    logic [1:0]  pick_idx;
    logic        pick_valid;

    function automatic logic [8:0] dur_last(input logic [1:0] idx);
        case (idx)
            2'd0:    dur_last = 9'(DUR0_MS - 1);
            2'd1:    dur_last = 9'(DUR1_MS - 1);
            2'd2:    dur_last = 9'(DUR2_MS - 1);
            default: dur_last = 9'(DUR3_MS - 1);
        endcase
    endfunction

    function automatic logic [16:0] half_period(input logic [1:0] idx);
        case (idx)
            2'd0:    half_period = 17'(HP0);
            2'd1:    half_period = 17'(HP1);
            2'd2:    half_period = 17'(HP2);
            default: half_period = 17'(HP3);
        endcase
    endfunction

    // New edges are merged into pending before arbitration so a request arriving
    // on an expiry cycle competes in that same decision.
    always_comb begin
        edges     = req & ~req_q;
        accepted  = gameplay_active ? (edges & 4'b1000) : edges;
        pend_upd  = (gameplay_active ? (pending & 4'b1000) : pending) | accepted;
        tick_wrap = (prescaler == PRESC_LAST);
        play_done = (state == PLAY) && tick_wrap && (ms_cnt == dur_last(tone_sel));
        gap_done  = (state == GAP) && tick_wrap && (ms_cnt == GAP_LAST);

        pick_valid = 1'b1;
        if (pend_upd[3])      pick_idx = 2'd3;
        else if (pend_upd[0]) pick_idx = 2'd0;
        else if (pend_upd[1]) pick_idx = 2'd1;
        else if (pend_upd[2]) pick_idx = 2'd2;
        else begin
            pick_idx   = 2'd0;
            pick_valid = 1'b0;
        end

        preempt    = (state != IDLE) && (tone_sel != 2'd3) && accepted[3];
        retrig     = !preempt && (state == PLAY) && accepted[tone_sel];
        to_gap     = 1'b0;
        to_idle    = 1'b0;
        start_play = 1'b0;
        start_idx  = 2'd0;
        pend_next  = pend_upd;

        if (preempt) begin
            start_play = 1'b1;
            start_idx  = 2'd3;
            pend_next  = pend_upd & 4'b0111;
        end else if (retrig) begin
            pend_next = pend_upd & ~(4'b0001 << tone_sel);
        end else if ((state == PLAY) && (play_done || (gameplay_active && tone_sel != 2'd3))) begin
            to_gap = 1'b1;
        end else if ((state == IDLE) || gap_done) begin
            if (pick_valid) begin
                start_play = 1'b1;
                start_idx  = pick_idx;
                pend_next  = pend_upd & ~(4'b0001 << pick_idx);
            end else begin
                to_idle = 1'b1;
            end
        end
    end

    // Every phase change and retrigger restarts both the ms prescaler and ms counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= IDLE;
            req_q            <= 4'b0;
            prescaler        <= 16'd0;
            ms_cnt           <= 9'd0;
            pending          <= 4'b0;
            grant            <= 4'b0;
            tone_en          <= 1'b0;
            tone_half_period <= 17'd0;
            tone_sel         <= 2'd0;
            busy             <= 1'b0;
        end else begin
            req_q   <= req;
            pending <= pend_next;
            grant   <= 4'b0;
            if (start_play || retrig || to_gap || to_idle) begin
                prescaler <= 16'd0;
                ms_cnt    <= 9'd0;
            end else if (tick_wrap) begin
                prescaler <= 16'd0;
                ms_cnt    <= ms_cnt + 9'd1;
            end else begin
                prescaler <= prescaler + 16'd1;
            end

            if (start_play) begin
                state            <= PLAY;
                grant            <= 4'b0001 << start_idx;
                tone_en          <= 1'b1;
                busy             <= 1'b1;
                tone_sel         <= start_idx;
                tone_half_period <= half_period(start_idx);
            end else if (retrig) begin
                grant <= 4'b0001 << tone_sel;
            end else if (to_gap) begin
                state   <= GAP;
                tone_en <= 1'b0;
            end else if (to_idle) begin
                state            <= IDLE;
                tone_en          <= 1'b0;
                busy             <= 1'b0;
                tone_sel         <= 2'd0;
                tone_half_period <= 17'd0;
            end
        end
    end

endmodule

// File: tb/tb_sfx_arbiter.sv
// Self-checking bench for sfx_arbiter: directed scenarios with literal expectations
// plus a randomized phase, all compared each cycle against a countdown-based model.
module tb_sfx_arbiter;

    localparam int TD   = 4;
    localparam int GMS  = 2;
    localparam int GAPC = TD * GMS;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req = 4'b0;
    logic        gameplay_active = 1'b0;
    logic        tone_en;
    logic [16:0] tone_half_period;
    logic [1:0]  tone_sel;
    logic [3:0]  grant;
    logic [3:0]  pending;
    logic        busy;

    int checks = 0;
    int errors = 0;

    sfx_arbiter #(
        .TICK_DIV (TD),
        .GAP_MS   (GMS),
        .DUR0_MS  (80),
        .DUR1_MS  (80),
        .DUR2_MS  (40),
        .DUR3_MS  (500),
        .HP0      (56818),
        .HP1      (28409),
        .HP2      (14205),
        .HP3      (113636)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .req              (req),
        .gameplay_active  (gameplay_active),
        .tone_en          (tone_en),
        .tone_half_period (tone_half_period),
        .tone_sel         (tone_sel),
        .grant            (grant),
        .pending          (pending),
        .busy             (busy)
    );

    always #5 clk = ~clk;

    // Reference model: an effect is a remaining-cycle countdown, no prescaler.
    int         m_st = 0;
    int         m_idx = 0;
    int         m_remain = 0;
    logic [3:0] m_pend = 4'b0;
    logic [3:0] m_prev = 4'b0;
    logic [3:0] m_grant = 4'b0;

    function automatic int durCycles(input int idx);
        int ms [4] = '{80, 80, 40, 500};
        return ms[idx] * TD;
    endfunction

    function automatic int hpOf(input int idx);
        int hp [4] = '{56818, 28409, 14205, 113636};
        return hp[idx];
    endfunction

    function automatic int pickHighest(input logic [3:0] p);
        int order [4] = '{3, 0, 1, 2};
        for (int i = 0; i < 4; i++)
            if (p[order[i]]) return order[i];
        return -1;
    endfunction

    task automatic startModel(input int idx);
        m_st     = 1;
        m_idx    = idx;
        m_remain = durCycles(idx);
        m_pend[idx] = 1'b0;
        m_grant  = 4'(1 << idx);
    endtask

    always @(posedge clk or posedge rst) begin
        logic [3:0] e;
        int nxt;
        if (rst) begin
            m_st = 0; m_idx = 0; m_remain = 0;
            m_pend = 4'b0; m_prev = 4'b0; m_grant = 4'b0;
        end else begin
            e = req & ~m_prev;
            m_prev = req;
            m_grant = 4'b0;
            if (gameplay_active) begin
                e = e & 4'b1000;
                m_pend = m_pend & 4'b1000;
            end
            if (m_st != 0 && m_idx != 3 && e[3]) begin
                m_pend = m_pend | (e & 4'b0111);
                startModel(3);
            end else if (m_st == 1 && e[m_idx]) begin
                m_pend = m_pend | (e & ~4'(1 << m_idx));
                m_remain = durCycles(m_idx);
                m_grant = 4'(1 << m_idx);
            end else begin
                m_pend = m_pend | e;
                if (m_st == 1 && gameplay_active && m_idx != 3) begin
                    m_st = 2; m_remain = GAPC;
                end else if (m_st == 1) begin
                    m_remain--;
                    if (m_remain == 0) begin m_st = 2; m_remain = GAPC; end
                end else begin
                    if (m_st == 2) m_remain--;
                    if (m_st == 0 || m_remain == 0) begin
                        nxt = pickHighest(m_pend);
                        if (nxt >= 0) startModel(nxt);
                        else begin m_st = 0; m_idx = 0; end
                    end
                end
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        logic        e_en, e_busy;
        logic [16:0] e_hp;
        logic [1:0]  e_sel;
        e_en   = (m_st == 1);
        e_busy = (m_st != 0);
        e_hp   = (m_st == 0) ? 17'd0 : 17'(hpOf(m_idx));
        e_sel  = (m_st == 0) ? 2'd0 : 2'(m_idx);
        checks++;
        if (tone_en !== e_en || busy !== e_busy || tone_half_period !== e_hp ||
            tone_sel !== e_sel || grant !== m_grant || pending !== m_pend) begin
            errors++;
            $display("[TB] FAIL model t=%0t got en=%b busy=%b hp=%0d sel=%0d grant=%b pend=%b want en=%b busy=%b hp=%0d sel=%0d grant=%b pend=%b",
                     $time, tone_en, busy, tone_half_period, tone_sel, grant, pending,
                     e_en, e_busy, e_hp, e_sel, m_grant, m_pend);
        end
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s got %0d want %0d", name, actual, expected);
        end
    endtask

    // Drive a one-cycle request pulse; returns on the negedge after it was sampled.
    task automatic applyStimulus(input logic [3:0] r);
        req = r;
        @(negedge clk);
        req = 4'b0;
    endtask

    // Counts consecutive cycles of tone on (mode 0) or gap silence (mode 1).
    task automatic countWhile(input int mode, output int n);
        n = 0;
        while (((mode == 0) ? tone_en : (busy && !tone_en)) && n < 5000) begin
            n++;
            @(negedge clk);
        end
    endtask

    initial begin
        int n;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("reset_busy", int'(busy), 0);
        checkOutput("reset_hp", int'(tone_half_period), 0);
        checkOutput("reset_pending", int'(pending), 0);

        applyStimulus(4'b0001);
        checkOutput("single_grant", int'(grant), 1);
        checkOutput("single_hp", int'(tone_half_period), 56818);
        countWhile(0, n);
        checkOutput("single_len", n, 320);
        countWhile(1, n);
        checkOutput("single_gap", n, 8);
        checkOutput("single_idle", int'(busy), 0);

        applyStimulus(4'b0101);
        checkOutput("simul_grant0", int'(grant), 1);
        checkOutput("simul_pend", int'(pending), 4);
        countWhile(0, n);
        checkOutput("simul_len0", n, 320);
        countWhile(1, n);
        checkOutput("simul_gap", n, 8);
        checkOutput("simul_grant2", int'(grant), 4);
        checkOutput("simul_hp2", int'(tone_half_period), 14205);
        checkOutput("simul_pend_empty", int'(pending), 0);
        countWhile(0, n);
        checkOutput("simul_len2", n, 160);
        countWhile(1, n);

        applyStimulus(4'b0010);
        checkOutput("pre_grant1", int'(grant), 2);
        repeat (99) @(negedge clk);
        applyStimulus(4'b1000);
        checkOutput("pre_grant3", int'(grant), 8);
        checkOutput("pre_tone_on", int'(tone_en), 1);
        countWhile(0, n);
        checkOutput("pre_len3", n, 2000);
        countWhile(1, n);
        checkOutput("pre_no_replay", int'(busy), 0);

        gameplay_active = 1'b1;
        applyStimulus(4'b0001);
        applyStimulus(4'b0010);
        applyStimulus(4'b0100);
        checkOutput("mute_pending", int'(pending), 0);
        checkOutput("mute_tone", int'(tone_en), 0);
        applyStimulus(4'b1000);
        checkOutput("mute_grant3", int'(grant), 8);
        countWhile(0, n);
        checkOutput("mute_len3", n, 2000);
        countWhile(1, n);
        gameplay_active = 1'b0;

        applyStimulus(4'b0100);
        repeat (99) @(negedge clk);
        applyStimulus(4'b0100);
        checkOutput("retrig_grant", int'(grant), 4);
        checkOutput("retrig_pending", int'(pending), 0);
        countWhile(0, n);
        checkOutput("retrig_total", 100 + n, 260);
        countWhile(1, n);

        applyStimulus(4'b0001);
        applyStimulus(4'b0010);
        checkOutput("rst_pre_pending", int'(pending), 2);
        repeat (20) @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        checkOutput("rst_async_tone", int'(tone_en), 0);
        checkOutput("rst_async_busy", int'(busy), 0);
        checkOutput("rst_async_pend", int'(pending), 0);
        checkOutput("rst_async_hp", int'(tone_half_period), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        checkOutput("rst_after_busy", int'(busy), 0);
        checkOutput("rst_after_grant", int'(grant), 0);

        for (int c = 0; c < 15000; c++) begin
            logic [3:0] r;
            r[0] = ($urandom_range(0, 59) == 0);
            r[1] = ($urandom_range(0, 59) == 0);
            r[2] = ($urandom_range(0, 59) == 0);
            r[3] = ($urandom_range(0, 399) == 0);
            req = r;
            if ($urandom_range(0, 699) == 0) gameplay_active = ~gameplay_active;
            @(negedge clk);
        end
        req = 4'b0;
        gameplay_active = 1'b0;
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
